// File: rtl/sequence_player.sv
// Plays a latched Simon colour sequence on four one-hot LEDs: each step is lit for ON_TICKS
// tick pulses, then blanked for GAP_TICKS, and a single-cycle done pulse ends the round.
module sequence_player #(
   parameter int MAX_LEN   = 8,
   parameter int LEN_W     = 4,
   parameter int ON_TICKS  = 4,
   parameter int GAP_TICKS = 2
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   start,
   input  logic                   abort,
   input  logic                   tick,
   input  logic [LEN_W-1:0]       seq_len,
   input  logic [2*MAX_LEN-1:0]   seq_data,
   output logic [3:0]             led,
   output logic                   busy,
   output logic                   done,
   output logic [LEN_W-1:0]       step_idx
);

   localparam int TMR_MAX = (ON_TICKS > GAP_TICKS) ? ON_TICKS : GAP_TICKS;
   localparam int TMR_W   = (TMR_MAX < 2) ? 1 : $clog2(TMR_MAX);

   typedef enum logic [1:0] {IDLE, ON, GAP, DONE} state_t;

   state_t                 state_q;
   logic [TMR_W-1:0]       timer_q;
   logic [2*MAX_LEN-1:0]   seq_q;
   logic [LEN_W-1:0]       len_q;
   logic [LEN_W-1:0]       step_idx_q;
   logic [3:0]             led_q;
   logic                   busy_q;
   logic                   done_q;
   logic [LEN_W-1:0]       eff_len_d;

   // Loop-based select keeps every bit select in range whatever idx holds.
   function automatic logic [3:0] led_for(input logic [2*MAX_LEN-1:0] d,
                                          input logic [LEN_W-1:0] idx);
      logic [1:0] c;
      c = 2'b00;
      for (int i = 0; i < MAX_LEN; i++) begin
         if (idx == LEN_W'(i)) c = d[2*i +: 2];
      end
      return 4'(4'b0001 << c);
   endfunction

   always_comb begin
      eff_len_d = seq_len;
      if (seq_len > LEN_W'(MAX_LEN)) eff_len_d = LEN_W'(MAX_LEN);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         timer_q    <= '0;
         seq_q      <= '0;
         len_q      <= '0;
         step_idx_q <= '0;
         led_q      <= '0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
      end else if (abort && state_q != IDLE) begin
         state_q    <= IDLE;
         timer_q    <= '0;
         step_idx_q <= '0;
         led_q      <= '0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (start) begin
                  seq_q      <= seq_data;
                  len_q      <= eff_len_d;
                  timer_q    <= '0;
                  step_idx_q <= '0;
                  busy_q     <= 1'b1;
                  if (eff_len_d == '0) begin
                     state_q <= DONE;
                     done_q  <= 1'b1;
                  end else begin
                     state_q <= ON;
                     led_q   <= led_for(seq_data, '0);
                  end
               end
            end
            ON: begin
               if (tick) begin
                  if (timer_q == TMR_W'(ON_TICKS - 1)) begin
                     state_q <= GAP;
                     timer_q <= '0;
                     led_q   <= '0;
                  end else begin
                     timer_q <= timer_q + TMR_W'(1);
                  end
               end
            end
            GAP: begin
               if (tick) begin
                  if (timer_q == TMR_W'(GAP_TICKS - 1)) begin
                     timer_q <= '0;
                     if (step_idx_q == len_q - LEN_W'(1)) begin
                        state_q <= DONE;
                        done_q  <= 1'b1;
                     end else begin
                        state_q    <= ON;
                        step_idx_q <= step_idx_q + LEN_W'(1);
                        led_q      <= led_for(seq_q, step_idx_q + LEN_W'(1));
                     end
                  end else begin
                     timer_q <= timer_q + TMR_W'(1);
                  end
               end
            end
            DONE: begin
               state_q    <= IDLE;
               done_q     <= 1'b0;
               busy_q     <= 1'b0;
               step_idx_q <= '0;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign led      = led_q;
   assign busy     = busy_q;
   assign done     = done_q;
   assign step_idx = step_idx_q;

endmodule

// File: tb/tb_sequence_player.sv
// Directed bench for sequence_player with ON_TICKS=3, GAP_TICKS=2; expected LED streams
// are built from the colour list handed to each playback.
module tb_sequence_player;
   localparam int MAX_LEN   = 8;
   localparam int LEN_W     = 4;
   localparam int ON_TICKS  = 3;
   localparam int GAP_TICKS = 2;
   localparam int STEP_T    = ON_TICKS + GAP_TICKS;

   logic                 clk = 1'b0;
   logic                 rst;
   logic                 start;
   logic                 abort;
   logic                 tick;
   logic [LEN_W-1:0]     seq_len;
   logic [2*MAX_LEN-1:0] seq_data;
   logic [3:0]           led;
   logic                 busy;
   logic                 done;
   logic [LEN_W-1:0]     step_idx;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   sequence_player #(
      .MAX_LEN  (MAX_LEN),
      .LEN_W    (LEN_W),
      .ON_TICKS (ON_TICKS),
      .GAP_TICKS(GAP_TICKS)
   ) dut (
      .clk     (clk),
      .rst     (rst),
      .start   (start),
      .abort   (abort),
      .tick    (tick),
      .seq_len (seq_len),
      .seq_data(seq_data),
      .led     (led),
      .busy    (busy),
      .done    (done),
      .step_idx(step_idx)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic check_idle(input string tag);
      check({tag, " led"}, 32'(led), 32'd0);
      check({tag, " busy"}, 32'(busy), 32'd0);
      check({tag, " done"}, 32'(done), 32'd0);
      check({tag, " step_idx"}, 32'(step_idx), 32'd0);
   endtask

   // Start a playback and compare every cycle against the expected stream.
   // Tick is high in cycle c when c % p == 0; disturb re-drives inputs mid-play.
   task automatic play(input string tag, input int len, input logic [15:0] data,
                       input int n_steps, input int p, input bit disturb);
      int         total;
      int         s;
      int         ph;
      logic [1:0] col;
      seq_len  = LEN_W'(len);
      seq_data = data;
      start    = 1'b1;
      tick     = 1'b1;
      next_cycle();
      start = 1'b0;
      total = n_steps * STEP_T * p + 1;
      for (int c = 1; c <= total; c++) begin
         if (c < total) begin
            s   = (c - 1) / (STEP_T * p);
            ph  = (c - 1) % (STEP_T * p);
            col = data[2*s +: 2];
            check($sformatf("%s c%0d led", tag, c), 32'(led),
                  (ph < ON_TICKS * p) ? (32'd1 << col) : 32'd0);
            check($sformatf("%s c%0d step_idx", tag, c), 32'(step_idx), 32'(s));
            check($sformatf("%s c%0d done", tag, c), 32'(done), 32'd0);
         end else begin
            check($sformatf("%s c%0d done", tag, c), 32'(done), 32'd1);
            check($sformatf("%s c%0d led", tag, c), 32'(led), 32'd0);
         end
         check($sformatf("%s c%0d busy", tag, c), 32'(busy), 32'd1);
         tick = (c % p == 0);
         if (disturb && c == 7) begin
            seq_data = ~data;
            seq_len  = LEN_W'(1);
            start    = 1'b1;
         end else begin
            start = 1'b0;
         end
         next_cycle();
      end
      tick = 1'b1;
      check_idle({tag, " end"});
   endtask

   task automatic no_done_for(input string tag, input int n);
      for (int c = 0; c < n; c++) begin
         check($sformatf("%s c%0d done", tag, c), 32'(done), 32'd0);
         check($sformatf("%s c%0d busy", tag, c), 32'(busy), 32'd0);
         next_cycle();
      end
   endtask

   initial begin
      rst      = 1'b1;
      start    = 1'b1;
      abort    = 1'b0;
      tick     = 1'b1;
      seq_len  = LEN_W'(3);
      seq_data = 16'h0027;
      next_cycle();
      next_cycle();
      check_idle("reset");
      rst   = 1'b0;
      start = 1'b0;
      next_cycle();
      check_idle("post reset");

      // 6'b10_01_11: colours 3,1,2 -> led 1000, 0010, 0100
      play("basic", 3, 16'h0027, 3, 1, 1'b0);
      play("disturb", 3, 16'h0027, 3, 1, 1'b1);
      play("len0", 0, 16'h0027, 0, 1, 1'b0);
      play("clamp", 15, 16'hE4B1, MAX_LEN, 1, 1'b0);
      play("slow tick", 1, 16'h0000, 1, 4, 1'b0);

      // abort while in the gap after step 1
      seq_len  = LEN_W'(3);
      seq_data = 16'h0027;
      start    = 1'b1;
      next_cycle();
      start = 1'b0;
      for (int c = 1; c < 9; c++) next_cycle();
      check("abort pre step_idx", 32'(step_idx), 32'd1);
      check("abort pre led", 32'(led), 32'd0);
      check("abort pre busy", 32'(busy), 32'd1);
      abort = 1'b1;
      next_cycle();
      abort = 1'b0;
      check_idle("abort");
      no_done_for("after abort", 20);
      play("replay abort", 3, 16'h0027, 3, 1, 1'b0);

      // synchronous reset in the middle of an ON step
      start = 1'b1;
      next_cycle();
      start = 1'b0;
      next_cycle();
      check("rst pre led", 32'(led), 32'h8);
      rst = 1'b1;
      next_cycle();
      rst = 1'b0;
      check_idle("mid rst");
      no_done_for("after rst", 20);
      play("replay rst", 3, 16'h0027, 3, 1, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
